// File: rtl/ddr2_controller_ex_rdata_check.sv
// Read-data checker for the DDR2 example driver: steps the per-lane LFSRs once per
// valid read beat, compares each beat with exp_data and reports per-run results.
module ddr2_controller_ex_rdata_check #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_beats,
  input  logic [DWIDTH-1:0]     rdata,
  input  logic                  rdata_valid,
  input  logic [DWIDTH-1:0]     exp_data,
  output logic                  lfsr_enable,
  output logic                  lfsr_pause,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [DWIDTH/8-1:0]   lane_fail,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      first_err_beat,
  output logic                  stray_valid
);
  localparam int NL = DWIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  // Handshake: a beat is consumed on every posedge where rdata_valid=1 while in CHECK;
  // there is no backpressure, and lfsr_pause drops in that same cycle so the LFSRs step with it.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic [NL-1:0]     lane_fail_q, lane_fail_d;
  logic              fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              stray_q, stray_d;
  logic              lfsr_en_q, lfsr_en_d;
  logic [NL-1:0]     lane_mis;
  logic              beat_acc;

  always_comb begin
    lane_mis = '0;
    for (int i = 0; i < NL; i++) begin
      lane_mis[i] = (rdata[8*i +: 8] != exp_data[8*i +: 8]);
    end
  end

  assign beat_acc = (state_q == S_CHECK) && rdata_valid;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    beat_d      = beat_q;
    err_d       = err_q;
    first_d     = first_q;
    lane_fail_d = lane_fail_q;
    fail_d      = fail_q;
    pass_d      = pass_q;
    stray_d     = stray_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d       = num_beats;
          beat_d      = '0;
          err_d       = '0;
          first_d     = '0;
          lane_fail_d = '0;
          fail_d      = 1'b0;
          pass_d      = 1'b0;
          stray_d     = 1'b0;
          state_d     = (num_beats == '0) ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (beat_acc) begin
          beat_d = beat_q + CNT_W'(1);
          if (|lane_mis) begin
            lane_fail_d = lane_fail_q | lane_mis;
            fail_d      = 1'b1;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!fail_q) first_d = beat_q;
          end
          if (beat_q == num_q - CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A valid seen in the same cycle as the accepting start is still recorded as stray.
    if (rdata_valid && (state_q != S_CHECK)) stray_d = 1'b1;
    // pass is resolved on entry to DONE so it already includes a final-beat mismatch.
    if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = !fail_d;
  end

  assign lfsr_en_d = (state_d == S_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      beat_q      <= '0;
      err_q       <= '0;
      first_q     <= '0;
      lane_fail_q <= '0;
      fail_q      <= 1'b0;
      pass_q      <= 1'b0;
      stray_q     <= 1'b0;
      lfsr_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      first_q     <= first_d;
      lane_fail_q <= lane_fail_d;
      fail_q      <= fail_d;
      pass_q      <= pass_d;
      stray_q     <= stray_d;
      lfsr_en_q   <= lfsr_en_d;
    end
  end

  assign lfsr_enable    = lfsr_en_q;
  assign lfsr_pause     = !beat_acc;
  assign busy           = (state_q == S_CHECK) || (state_q == S_DONE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign lane_fail      = lane_fail_q;
  assign err_count      = err_q;
  assign first_err_beat = first_q;
  assign stray_valid    = stray_q;

endmodule

// File: tb/tb_ddr2_controller_ex_rdata_check.sv
// Bench for ddr2_controller_ex_rdata_check: lane LFSRs driven by the DUT's enable/pause,
// randomized runs checked against a per-run model of expected LFSR values and results.
module tb_ddr2_controller_ex_rdata_check;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NL = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_beats = '0;
  logic [DW-1:0] rdata = '0;
  logic          rdata_valid = 1'b0;
  logic [DW-1:0] exp_data;
  logic          lfsr_enable, lfsr_pause, busy, done, pass, fail, stray_valid;
  logic [NL-1:0] lane_fail;
  logic [CW-1:0] err_count, first_err_beat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] seed_v [NL];
  logic [7:0] env_q  [NL];

  ddr2_controller_ex_rdata_check #(.DWIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_beats(num_beats),
    .rdata(rdata), .rdata_valid(rdata_valid), .exp_data(exp_data),
    .lfsr_enable(lfsr_enable), .lfsr_pause(lfsr_pause), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .lane_fail(lane_fail), .err_count(err_count),
    .first_err_beat(first_err_beat), .stray_valid(stray_valid)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // x^8+x^4+x^3+x^2+1, left-shifting: 0x20 -> 0x40 -> 0x80 -> 0x1D
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
  endfunction

  // Lane pattern generators, external to the checker.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (!lfsr_enable)     env_q[i] <= seed_v[i];
      else if (!lfsr_pause) env_q[i] <= lfsr_step(env_q[i]);
    end
  end

  always_comb begin
    exp_data = '0;
    for (int i = 0; i < NL; i++) exp_data[8*i +: 8] = env_q[i];
  end

  task automatic set_seeds(input logic [7:0] s, input bit rnd);
    for (int i = 0; i < NL; i++) seed_v[i] = rnd ? 8'($urandom_range(1, 255)) : s;
  endtask

  // ---- driver: one complete run with scoreboard ----
  task automatic do_run(input int n, input int max_gap, input int err_pct,
                        input int force_beat, input int force_lane,
                        input int restart_at, input string tag);
    logic [7:0]    m [NL];
    logic [DW-1:0] good, data;
    logic [DW-1:0] exp_q [$];
    logic [NL-1:0] e_lane;
    int            e_err, e_first, lane;
    for (int i = 0; i < NL; i++) m[i] = seed_v[i];
    // expected beats come from the LFSR rule applied to the seeds
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NL; i++) begin
        good[8*i +: 8] = m[i];
        m[i] = lfsr_step(m[i]);
      end
      exp_q.push_back(good);
    end
    e_lane = '0; e_err = 0; e_first = 0;
    @(negedge clk);
    start = 1'b1; num_beats = CW'(n);
    @(negedge clk);
    start = 1'b0; num_beats = CW'($urandom_range(0, 20));
    n_cmp++;
    if ({busy, done, pass, fail, lane_fail, err_count, stray_valid, lfsr_enable} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {NL{1'b0}}, {CW{1'b0}}, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s_start: busy=%b done=%b pass=%b fail=%b lane=%b err=%0d stray=%b en=%b required 1 0 0 0 0 0 0 1",
               tag, busy, done, pass, fail, lane_fail, err_count, stray_valid, lfsr_enable);
    end
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        rdata_valid = 1'b0; rdata = $urandom;
        #1;
        n_cmp++;
        if (lfsr_pause !== 1'b1) begin
          n_bad++; $display("FAIL %s_gap_pause: got %b required 1", tag, lfsr_pause);
        end
        @(negedge clk);
      end
      good = exp_q.pop_front();
      data = good;
      if ((k == force_beat) || (int'($urandom_range(0, 99)) < err_pct)) begin
        lane = (k == force_beat) ? force_lane : int'($urandom_range(0, NL - 1));
        data[8*lane +: 8] = (good[8*lane +: 8] == 8'hFF) ? 8'h00 : 8'hFF;
      end
      for (int i = 0; i < NL; i++)
        if (data[8*i +: 8] != good[8*i +: 8]) e_lane[i] = 1'b1;
      if (data != good) begin
        if (e_err == 0) e_first = k;
        e_err++;
      end
      rdata = data; rdata_valid = 1'b1;
      if (k == restart_at) begin start = 1'b1; num_beats = CW'(n + 5); end
      #1;
      n_cmp++;
      if (lfsr_pause !== 1'b0) begin
        n_bad++; $display("FAIL %s_beat_pause: beat %0d got %b required 0", tag, k, lfsr_pause);
      end
      @(negedge clk);
      rdata_valid = 1'b0; start = 1'b0;
      if (k < n - 1) begin
        n_cmp++;
        if ({busy, done, pass} !== 3'b100) begin
          n_bad++; $display("FAIL %s_midrun: beat %0d busy/done/pass=%b required 100", tag, k, {busy, done, pass});
        end
      end
    end
    n_cmp++;
    if ({done, busy, pass, fail, lane_fail, err_count, first_err_beat} !==
        {1'b1, 1'b1, e_err == 0, e_err != 0, e_lane, CW'(e_err), CW'(e_first)}) begin
      n_bad++;
      $display("FAIL %s_done: done=%b busy=%b pass=%b fail=%b lane=%b err=%0d first=%0d required 1 1 %b %b %b %0d %0d",
               tag, done, busy, pass, fail, lane_fail, err_count, first_err_beat,
               e_err == 0, e_err != 0, e_lane, e_err, e_first);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, lfsr_enable, pass, fail} !== {3'b000, e_err == 0, e_err != 0}) begin
      n_bad++;
      $display("FAIL %s_after: done=%b busy=%b en=%b pass=%b fail=%b required 0 0 0 %b %b",
               tag, done, busy, lfsr_enable, pass, fail, e_err == 0, e_err != 0);
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    set_seeds(8'h20, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, fail, lane_fail, err_count, first_err_beat, stray_valid, lfsr_enable, lfsr_pause} !==
        {4'b0000, {NL{1'b0}}, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b pass=%b fail=%b lane=%b err=%0d first=%0d stray=%b en=%b pause=%b required all 0, pause 1",
               busy, done, pass, fail, lane_fail, err_count, first_err_beat, stray_valid, lfsr_enable, lfsr_pause);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_seeds(8'h20, 0);
    do_run(4, 0, 0, -1, 0, -1, "basic");
  endtask

  task automatic test_gaps();
    set_seeds(8'h20, 0);
    do_run(4, 3, 0, -1, 0, -1, "gaps");
  endtask

  task automatic test_lane_error();
    set_seeds(8'h20, 0);
    do_run(4, 0, 0, 2, 2, -1, "lane2");
    do_run(5, 1, 0, 4, 0, -1, "last_beat");
  endtask

  task automatic test_zero_beats();
    bit en_seen = 0;
    @(negedge clk);
    start = 1'b1; num_beats = '0;
    @(negedge clk);
    start = 1'b0;
    en_seen |= lfsr_enable;
    n_cmp++;
    if ({done, pass, fail, err_count} !== {3'b110, {CW{1'b0}}}) begin
      n_bad++; $display("FAIL zero_done: done=%b pass=%b fail=%b err=%0d required 1 1 0 0", done, pass, fail, err_count);
    end
    repeat (2) begin @(negedge clk); en_seen |= lfsr_enable; end
    n_cmp++;
    if ({done, busy, pass, en_seen} !== 4'b0010) begin
      n_bad++; $display("FAIL zero_after: done=%b busy=%b pass=%b en_seen=%b required 0 0 1 0", done, busy, pass, en_seen);
    end
  endtask

  task automatic test_stray_restart();
    set_seeds(8'h20, 0);
    @(negedge clk);
    rdata_valid = 1'b1; rdata = $urandom;
    #1;
    n_cmp++;
    if (lfsr_pause !== 1'b1) begin
      n_bad++; $display("FAIL stray_pause: got %b required 1", lfsr_pause);
    end
    @(negedge clk);
    rdata_valid = 1'b0;
    n_cmp++;
    if ({stray_valid, busy} !== 2'b10) begin
      n_bad++; $display("FAIL stray_set: stray=%b busy=%b required 1 0", stray_valid, busy);
    end
    do_run(4, 2, 0, -1, 0, 1, "restart");
  endtask

  task automatic test_reset_midrun();
    set_seeds(8'h20, 0);
    @(negedge clk);
    start = 1'b1; num_beats = CW'(4);
    @(negedge clk);
    start = 1'b0;
    rdata = 32'h20FF2020; rdata_valid = 1'b1;
    @(negedge clk);
    rdata = 32'h40404040;
    @(negedge clk);
    rdata_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, pass, fail, lane_fail, err_count, first_err_beat, stray_valid, lfsr_enable, lfsr_pause} !==
        {4'b0000, {NL{1'b0}}, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midrun_reset: busy=%b done=%b pass=%b fail=%b lane=%b err=%0d en=%b pause=%b required all 0, pause 1",
               busy, done, pass, fail, lane_fail, err_count, lfsr_enable, lfsr_pause);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_bad++; $display("FAIL post_reset_idle: done=%b busy=%b required 0 0", done, busy);
      end
    end
    do_run(4, 0, 0, -1, 0, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      set_seeds(8'h00, 1);
      do_run(int'($urandom_range(1, 12)), 3, 25, -1, 0, -1, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_lane_error();
    test_zero_beats();
    test_stray_restart();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
